// File: rtl/vga_scanout_if.sv
// Framebuffer read port and video output bundle for vga_scanout.
// master = the scanout engine, slave = framebuffer / display side.
interface vga_scanout_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 16
);
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_data;
  logic                  hsync;
  logic                  vsync;
  logic                  blank_n;
  logic [DATA_WIDTH-1:0] rgb;
  logic                  frame_done;

  modport master (
    output mem_addr, hsync, vsync, blank_n, rgb, frame_done,
    input  mem_data
  );

  modport slave (
    input  mem_addr, hsync, vsync, blank_n, rgb, frame_done,
    output mem_data
  );
endinterface

// File: rtl/vga_scanout.sv
// 640x480@60 VGA scanout from a 160x120 RGB332 framebuffer (4x4 upscale).
// Pixel clock is clk/2 via a toggling enable; all video outputs are
// registered one pixel period behind the counters so the synchronous
// framebuffer read (one clk) lands exactly on the next pixel edge.
module vga_scanout #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 16
) (
  input  logic           clk,
  input  logic           rst,
  vga_scanout_if.master  vif
);

  localparam logic [9:0] H_LAST   = 10'd799;
  localparam logic [9:0] V_LAST   = 10'd524;
  localparam logic [9:0] H_ACTIVE = 10'd640;
  localparam logic [9:0] V_ACTIVE = 10'd480;
  localparam logic [9:0] HS_BEG   = 10'd656;
  localparam logic [9:0] HS_END   = 10'd751;
  localparam logic [9:0] VS_BEG   = 10'd490;
  localparam logic [9:0] VS_END   = 10'd491;

  logic       pix_en;
  logic [9:0] hc, vc;
  logic       active;
  logic [ADDR_WIDTH-1:0] row, col;

  // pixel-rate enable: first pixel edge is the second clk after reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pix_en <= 1'b0;
    else     pix_en <= ~pix_en;
  end

  // raster counters, advance once per pixel edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hc <= '0;
      vc <= '0;
    end else if (pix_en) begin
      if (hc == H_LAST) begin
        hc <= '0;
        vc <= (vc == V_LAST) ? 10'd0 : vc + 10'd1;
      end else begin
        hc <= hc + 10'd1;
      end
    end
  end

  // framebuffer address: (vc/4)*160 + hc/4, *160 done as two shifts
  always_comb begin
    active = (hc < H_ACTIVE) && (vc < V_ACTIVE);
    row    = ADDR_WIDTH'(vc[9:2]);
    col    = ADDR_WIDTH'(hc[9:2]);
    vif.mem_addr = active ? (row << 7) + (row << 5) + col : '0;
  end

  // video outputs sampled from pre-increment counters and returned data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vif.hsync   <= 1'b1;
      vif.vsync   <= 1'b1;
      vif.blank_n <= 1'b0;
      vif.rgb     <= '0;
    end else if (pix_en) begin
      vif.hsync   <= !((hc >= HS_BEG) && (hc <= HS_END));
      vif.vsync   <= !((vc >= VS_BEG) && (vc <= VS_END));
      vif.blank_n <= active;
      vif.rgb     <= active ? vif.mem_data : '0;
    end
  end

  // one-clk strobe after the pixel edge that enters vertical blanking
  always_ff @(posedge clk or posedge rst) begin
    if (rst) vif.frame_done <= 1'b0;
    else     vif.frame_done <= pix_en && (hc == H_LAST) && (vc == V_ACTIVE - 10'd1);
  end

endmodule

// File: tb/tb_vga_scanout.sv
// Directed bench for vga_scanout. A reference raster position (mh,mv) is
// tracked alongside the DUT; long vertical distances are skipped by
// depositing a new line number into both DUT and reference.
module tb_vga_scanout;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mem_ff = 1'b0;

  int checks = 0;
  int errors = 0;
  int fd_cnt = 0;

  vga_scanout_if #(.DATA_WIDTH(8), .ADDR_WIDTH(16)) vif ();

  vga_scanout #(.DATA_WIDTH(8), .ADDR_WIDTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .vif (vif)
  );

  always #10 clk = ~clk;

  // framebuffer: one-clk read latency, byte = addr[7:0] (or all ones)
  always @(posedge clk) vif.mem_data <= mem_ff ? 8'hFF : vif.mem_addr[7:0];

  // reference raster position
  logic       pen;
  logic [9:0] mh, mv, ph, pv;
  logic       jreq = 1'b0;
  logic [9:0] jv = '0;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pen <= 1'b0; mh <= '0; mv <= '0; ph <= '0; pv <= '0;
    end else begin
      pen <= ~pen;
      if (jreq) mv <= jv;
      else if (pen) begin
        ph <= mh; pv <= mv;
        if (mh == 10'd799) begin
          mh <= '0;
          mv <= (mv == 10'd524) ? 10'd0 : mv + 10'd1;
        end else mh <= mh + 10'd1;
      end
    end
  end

  always @(negedge clk) if (vif.frame_done) fd_cnt++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // stop at the first negedge where the counters sit at (h,v)
  task automatic wait_pos(input int h, input int v, input int bound);
    int n = 0;
    @(negedge clk);
    while (!(mh == 10'(h) && mv == 10'(v) && !pen) && n < bound) begin
      @(negedge clk);
      n++;
    end
    if (n >= bound) chk($sformatf("timeout_%0d_%0d", h, v), 32'd0, 32'd1);
  endtask

  // deposit line number v between pixel edges (DUT and reference)
  task automatic jump_vc(input logic [9:0] v);
    @(negedge clk);
    if (pen) @(negedge clk);
    force dut.vc = v;
    release dut.vc;
    jv = v; jreq = 1'b1;
    @(posedge clk);
    #1 jreq = 1'b0;
  endtask

  task automatic pix();
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int lo;
    int fd_before;
    // reset state
    repeat (3) @(negedge clk);
    chk("rst_hsync", vif.hsync, 1);
    chk("rst_vsync", vif.vsync, 1);
    chk("rst_blank", vif.blank_n, 0);
    chk("rst_rgb", vif.rgb, 0);
    chk("rst_fd", vif.frame_done, 0);
    chk("rst_addr", vif.mem_addr, 0);

    // line 0: hsync low for 96 pixel periods (192 clks)
    rst = 1'b0;
    lo = 0;
    repeat (1600) begin
      @(negedge clk);
      if (!vif.hsync) lo++;
    end
    chk("hsync_low_clks", lo, 192);

    // address mapping and one-pixel output latency
    wait_pos(8, 4, 8000);
    chk("addr_8_4", vif.mem_addr, 162);
    pix();
    chk("rgb_8_4", vif.rgb, 8'hA2);
    chk("blank_8_4", vif.blank_n, 1);

    // last active pixel and first front-porch pixel
    jump_vc(10'd479);
    wait_pos(639, 479, 4000);
    chk("addr_639_479", vif.mem_addr, 19199);
    wait_pos(640, 479, 10);
    chk("addr_640_479", vif.mem_addr, 0);
    chk("rgb_639_479", vif.rgb, 8'hFF);
    chk("blank_639_479", vif.blank_n, 1);
    pix();
    chk("rgb_640_479", vif.rgb, 0);
    chk("blank_640_479", vif.blank_n, 0);

    // frame_done: three frames, one-clk pulse as vc becomes 480
    for (int f = 0; f < 3; f++) begin
      if (f > 0) begin
        wait_pos(0, 481, 4000);
        jump_vc(10'd479);
      end
      wait_pos(0, 480, 4000);
      chk($sformatf("fd_hi_%0d", f), vif.frame_done, 1);
      @(negedge clk);
      chk($sformatf("fd_lo_%0d", f), vif.frame_done, 0);
    end
    chk("fd_count", fd_cnt, 3);

    // vsync low for 2 lines = 1600 pixel periods
    wait_pos(0, 481, 4000);
    jump_vc(10'd488);
    lo = 0;
    repeat (8000) begin
      @(negedge clk);
      if (!vif.vsync) lo++;
    end
    chk("vsync_low_clks", lo, 3200);

    // all-ones memory: colour only inside the active window
    mem_ff = 1'b1;
    jump_vc(10'd479);
    wait_pos(600, 479, 4000);
    repeat (1800) begin
      @(negedge clk);
      if (!pen) begin
        chk("ff_blank", vif.blank_n, (ph < 640 && pv < 480) ? 1 : 0);
        chk("ff_rgb", vif.rgb, (ph < 640 && pv < 480) ? 8'hFF : 8'h00);
        chk("ff_hsync", vif.hsync, (ph >= 656 && ph <= 751) ? 0 : 1);
      end
    end
    mem_ff = 1'b0;

    // reset in the middle of vertical sync
    wait_pos(0, 481, 4000);
    jump_vc(10'd490);
    wait_pos(700, 490, 4000);
    chk("pre_rst_vsync", vif.vsync, 0);
    chk("pre_rst_hsync", vif.hsync, 0);
    fd_before = fd_cnt;
    rst = 1'b1;
    #1;
    chk("arst_vsync", vif.vsync, 1);
    chk("arst_hsync", vif.hsync, 1);
    chk("arst_rgb", vif.rgb, 0);
    chk("arst_blank", vif.blank_n, 0);
    chk("arst_fd", vif.frame_done, 0);
    chk("arst_addr", vif.mem_addr, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    wait_pos(656, 0, 2000);
    chk("post_rst_hs_655", vif.hsync, 1);
    pix();
    chk("post_rst_hs_656", vif.hsync, 0);
    chk("no_fd_on_abort", fd_cnt, fd_before);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
